// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: registered result/control bundle behind a
// 2-entry skid buffer, plus BEQ/BNE redirect resolution.
module ex_mem_stage #(
   parameter int DATA_W = 32,
   parameter int RA_W   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_alu_ctrl,
   input  logic [DATA_W-1:0] in_result,
   input  logic              in_zero,
   input  logic              in_overflow,
   input  logic              in_branch,
   input  logic [DATA_W-1:0] in_br_target,
   input  logic [DATA_W-1:0] in_store_data,
   input  logic [RA_W-1:0]   in_rd,
   input  logic              in_reg_write,
   input  logic              in_mem_read,
   input  logic              in_mem_write,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              out_overflow,
   output logic [DATA_W-1:0] out_store_data,
   output logic [RA_W-1:0]   out_rd,
   output logic              out_reg_write,
   output logic              out_mem_read,
   output logic              out_mem_write,
   output logic              br_taken,
   output logic [DATA_W-1:0] br_pc
);

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic              overflow;
      logic [DATA_W-1:0] store_data;
      logic [RA_W-1:0]   rd;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
   } entry_t;

   entry_t main_q;
   entry_t skid_q;
   entry_t in_e;
   logic   main_v;
   logic   skid_v;
   logic   in_ready_q;
   logic   acc;
   logic   pop;
   logic   take;
   logic   is_br_code;
   logic   main_v_n;
   logic   skid_v_n;
   logic   ld_main_in;
   logic   ld_main_skid;
   logic   ld_skid;

   assign in_e = '{
      result:     in_result,
      overflow:   in_overflow,
      store_data: in_store_data,
      rd:         in_rd,
      reg_write:  in_reg_write,
      mem_read:   in_mem_read,
      mem_write:  in_mem_write
   };

   assign acc = in_valid & in_ready_q;
   assign pop = main_v & out_ready;

   // ALU zero already encodes "condition true" for both BEQ and BNE
   assign is_br_code = (in_alu_ctrl == 4'b1010) |
                       (in_alu_ctrl == 4'b1011);
   assign take = acc & in_branch & in_zero & is_br_code;

   always_comb begin
      main_v_n     = main_v;
      skid_v_n     = skid_v;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      if (!main_v) begin
         main_v_n   = acc;
         ld_main_in = acc;
      end else if (pop) begin
         if (skid_v) begin
            ld_main_skid = 1'b1;
            skid_v_n     = 1'b0;
         end else begin
            ld_main_in = acc;
            main_v_n   = acc;
         end
      end else if (acc) begin
         ld_skid  = 1'b1;
         skid_v_n = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_v     <= 1'b0;
         skid_v     <= 1'b0;
         in_ready_q <= 1'b0;
         br_taken   <= 1'b0;
         br_pc      <= '0;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (flush) begin
         main_v     <= 1'b0;
         skid_v     <= 1'b0;
         in_ready_q <= 1'b1;
         br_taken   <= 1'b0;
      end else begin
         main_v     <= main_v_n;
         skid_v     <= skid_v_n;
         in_ready_q <= ~skid_v_n;
         br_taken   <= take;
         if (take)
            br_pc <= in_br_target;
         if (ld_main_in)
            main_q <= in_e;
         else if (ld_main_skid)
            main_q <= skid_q;
         if (ld_skid)
            skid_q <= in_e;
      end
   end

   assign in_ready       = in_ready_q;
   assign out_valid      = main_v;
   assign out_result     = main_q.result;
   assign out_overflow   = main_q.overflow;
   assign out_store_data = main_q.store_data;
   assign out_rd         = main_q.rd;
   assign out_reg_write  = main_q.reg_write;
   assign out_mem_read   = main_q.mem_read;
   assign out_mem_write  = main_q.mem_write;

endmodule
